// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-buffer defaults, controller state encoding and frame-width helper
package uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int TO_W_DEF = 8;
  typedef enum logic [1:0] {ST_OFF, ST_FLUSH, ST_LISTEN} rx_state_e;
  function automatic logic [3:0] eff_width(input logic [3:0] n);
    return n < 4'd5 ? 4'd5 : (n > 4'd8 ? 4'd8 : n);
  endfunction
endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: show-ahead synchronous FIFO with flush, push/pop, full/empty and occupancy
module rx_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rd_ptr];
  // storage array, written on accepted pushes only
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  // pointers and occupancy; flush empties without touching storage
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl: receive enable FSM, frame buffering, sticky error flags, idle timeout and interrupt
module rx_buffer_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TO_W = TO_W_DEF
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       baud_tick,
  input  logic                       RXen,
  input  logic                       rx_done,
  input  logic                       error_rx_detect,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic [3:0]                 number_data_receive,
  input  logic                       rd_req,
  input  logic                       err_clr,
  input  logic [$clog2(DEPTH):0]     rx_threshold,
  input  logic [TO_W-1:0]            timeout_limit,
  output logic                       rx_en_out,
  output logic [DATA_W-1:0]          rx_fifo_data,
  output logic                       rx_fifo_empty,
  output logic                       rx_fifo_full,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       overrun_err,
  output logic                       frame_err,
  output logic                       rx_timeout,
  output logic                       rx_irq
);
  localparam logic [TO_W-1:0] TO_MAX = '1;
  rx_state_e state, state_nxt;
  logic flush, listen;
  logic frame_valid, err_valid, wr_ok, pop, ovr_set, to_inc, to_hit;
  logic [TO_W-1:0] to_cnt, to_sat;
  logic [DATA_W-1:0] mask;
  // state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= ST_OFF;
    else state <= state_nxt;
  end
  // next state and state-decoded controls; FLUSH lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    flush = 1'b0;
    listen = 1'b0;
    state_nxt = (state == ST_OFF) ? (RXen ? ST_FLUSH : ST_OFF) :
                (state == ST_FLUSH) ? ST_LISTEN : (RXen ? ST_LISTEN : ST_OFF);
    flush = state == ST_FLUSH;
    listen = state == ST_LISTEN;
  end
  assign rx_en_out = listen;
  assign frame_valid = rx_done & baud_tick & listen;
  assign err_valid = error_rx_detect & baud_tick & listen;
  assign wr_ok = frame_valid & ~err_valid;
  assign pop = rd_req & ~rx_fifo_empty;
  assign ovr_set = wr_ok & rx_fifo_full & ~rd_req;
  assign mask = ~({DATA_W{1'b1}} << eff_width(number_data_receive));
  rx_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .flush(flush),
    .push(wr_ok),
    .pop(rd_req),
    .wdata(rx_data & mask),
    .rdata(rx_fifo_data),
    .full(rx_fifo_full),
    .empty(rx_fifo_empty),
    .count(rx_count)
  );
  assign to_sat = timeout_limit != '0 ? timeout_limit : TO_MAX;
  assign to_inc = baud_tick & listen & ~rx_fifo_empty & ~frame_valid & ~pop & (to_cnt != to_sat);
  assign to_hit = to_inc & (timeout_limit != '0) & ((to_cnt + TO_W'(1)) == timeout_limit);
  // idle counter: restarts on any buffer activity, stops at the limit
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) to_cnt <= '0;
    else if (flush | frame_valid | pop | rx_fifo_empty) to_cnt <= '0;
    else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
  end
  // sticky flags; a same-cycle set beats the clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      overrun_err <= 1'b0;
      frame_err <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      overrun_err <= ovr_set | (overrun_err & ~err_clr);
      frame_err <= err_valid | (frame_err & ~err_clr);
      rx_timeout <= to_hit | (rx_timeout & ~err_clr);
    end
  end
  // registered interrupt from fill level and sticky flags
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) rx_irq <= 1'b0;
    else rx_irq <= ((rx_threshold != '0) & (rx_count >= rx_threshold)) | overrun_err | frame_err | rx_timeout;
  end
endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// tb_rx_buffer_ctrl: directed self-checking bench for rx_buffer_ctrl
module tb_rx_buffer_ctrl;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic baud_tick = 1'b0, RXen = 1'b0, rx_done = 1'b0, error_rx_detect = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] number_data_receive = 4'd8;
  logic rd_req = 1'b0, err_clr = 1'b0;
  logic [4:0] rx_threshold = '0;
  logic [7:0] timeout_limit = '0;
  logic rx_en_out, rx_fifo_empty, rx_fifo_full, overrun_err, frame_err, rx_timeout, rx_irq;
  logic [7:0] rx_fifo_data;
  logic [4:0] rx_count;
  int checks = 0;
  int errors = 0;
  always #5 PCLK = ~PCLK;
  rx_buffer_ctrl dut (
    .PCLK(PCLK), .PRESET(PRESET), .baud_tick(baud_tick), .RXen(RXen),
    .rx_done(rx_done), .error_rx_detect(error_rx_detect), .rx_data(rx_data),
    .number_data_receive(number_data_receive), .rd_req(rd_req), .err_clr(err_clr),
    .rx_threshold(rx_threshold), .timeout_limit(timeout_limit), .rx_en_out(rx_en_out),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full),
    .rx_count(rx_count), .overrun_err(overrun_err), .frame_err(frame_err),
    .rx_timeout(rx_timeout), .rx_irq(rx_irq)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [7:0] d, input logic rd);
    rx_data = d;
    rx_done = 1'b1;
    baud_tick = 1'b1;
    rd_req = rd;
    @(negedge PCLK);
    rx_done = 1'b0;
    baud_tick = 1'b0;
    rd_req = 1'b0;
  endtask
  task automatic pulse_rd();
    rd_req = 1'b1;
    @(negedge PCLK);
    rd_req = 1'b0;
  endtask
  task automatic tick();
    baud_tick = 1'b1;
    @(negedge PCLK);
    baud_tick = 1'b0;
    @(negedge PCLK);
  endtask
  task automatic clear_flags();
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge PCLK);
    check("rst_en", 32'(rx_en_out), 0);
    check("rst_empty", 32'(rx_fifo_empty), 1);
    check("rst_full", 32'(rx_fifo_full), 0);
    check("rst_count", 32'(rx_count), 0);
    check("rst_data", 32'(rx_fifo_data), 0);
    check("rst_irq", 32'(rx_irq), 0);
    check("rst_flags", 32'({overrun_err, frame_err, rx_timeout}), 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    RXen = 1'b1;
    @(negedge PCLK);
    check("flush_en", 32'(rx_en_out), 0);
    @(negedge PCLK);
    check("listen_en", 32'(rx_en_out), 1);
    frame(8'hA5, 1'b0);
    frame(8'h3C, 1'b0);
    frame(8'hFF, 1'b0);
    check("cnt3", 32'(rx_count), 3);
    check("head_a5", 32'(rx_fifo_data), 32'hA5);
    pulse_rd();
    check("head_3c", 32'(rx_fifo_data), 32'h3C);
    pulse_rd();
    check("head_ff", 32'(rx_fifo_data), 32'hFF);
    pulse_rd();
    check("drained_empty", 32'(rx_fifo_empty), 1);
    check("drained_data", 32'(rx_fifo_data), 0);
    pulse_rd();
    check("rd_empty_ignored", 32'(rx_count), 0);
    number_data_receive = 4'd5;
    frame(8'hFF, 1'b0);
    check("w5_mask", 32'(rx_fifo_data), 32'h1F);
    pulse_rd();
    number_data_receive = 4'd3;
    frame(8'hFF, 1'b0);
    check("w3_clamp", 32'(rx_fifo_data), 32'h1F);
    pulse_rd();
    number_data_receive = 4'd8;
    for (int i = 0; i < 16; i++) frame(8'(i + 1), 1'b0);
    check("full16", 32'(rx_fifo_full), 1);
    check("cnt16", 32'(rx_count), 16);
    check("no_ovr_yet", 32'(overrun_err), 0);
    frame(8'h77, 1'b0);
    check("ovr_set", 32'(overrun_err), 1);
    check("cnt_after_ovr", 32'(rx_count), 16);
    @(negedge PCLK);
    check("ovr_irq", 32'(rx_irq), 1);
    check("head_frame1", 32'(rx_fifo_data), 32'h01);
    clear_flags();
    check("ovr_cleared", 32'(overrun_err), 0);
    frame(8'h88, 1'b1);
    check("full_rw_cnt", 32'(rx_count), 16);
    check("full_rw_no_ovr", 32'(overrun_err), 0);
    for (int i = 0; i < 16; i++) begin
      check("drain_head", 32'(rx_fifo_data), i < 15 ? 32'(i + 2) : 32'h88);
      pulse_rd();
    end
    check("drain_empty", 32'(rx_fifo_empty), 1);
    @(negedge PCLK);
    timeout_limit = 8'd4;
    frame(8'h42, 1'b0);
    repeat (3) tick();
    check("to_before", 32'(rx_timeout), 0);
    baud_tick = 1'b1;
    @(negedge PCLK);
    baud_tick = 1'b0;
    check("to_set", 32'(rx_timeout), 1);
    @(negedge PCLK);
    check("to_irq", 32'(rx_irq), 1);
    clear_flags();
    check("to_cleared", 32'(rx_timeout), 0);
    @(negedge PCLK);
    check("to_irq_clear", 32'(rx_irq), 0);
    timeout_limit = 8'd0;
    pulse_rd();
    rx_threshold = 5'd2;
    frame(8'h11, 1'b0);
    @(negedge PCLK);
    check("thr_below", 32'(rx_irq), 0);
    frame(8'h22, 1'b0);
    @(negedge PCLK);
    check("thr_reached", 32'(rx_irq), 1);
    error_rx_detect = 1'b1;
    frame(8'h99, 1'b0);
    error_rx_detect = 1'b0;
    check("ferr_set", 32'(frame_err), 1);
    check("ferr_no_write", 32'(rx_count), 2);
    frame(8'h33, 1'b0);
    frame(8'h44, 1'b0);
    frame(8'h55, 1'b0);
    check("cnt5", 32'(rx_count), 5);
    rx_done = 1'b1;
    PRESET = 1'b1;
    #1;
    check("mid_rst_en", 32'(rx_en_out), 0);
    check("mid_rst_cnt", 32'(rx_count), 0);
    check("mid_rst_empty", 32'(rx_fifo_empty), 1);
    check("mid_rst_irq", 32'(rx_irq), 0);
    check("mid_rst_ferr", 32'(frame_err), 0);
    @(negedge PCLK);
    rx_done = 1'b0;
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    check("relisten_empty", 32'(rx_fifo_empty), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
